// File: rtl/mmio_pkg.sv
// Register map and shared helpers for the memory-mapped IO bridge.
package mmio_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BANK_W      = 8;
  localparam int unsigned REG_STRIDE  = 4;

  localparam int unsigned OFF_LED0    = 32'h00;
  localparam int unsigned OFF_SW0     = 32'h10;
  localparam int unsigned OFF_SEG     = 32'h20;
  localparam int unsigned OFF_BTN_LVL = 32'h30;
  localparam int unsigned OFF_BTN_EVT = 32'h34;
  localparam int unsigned OFF_CYC     = 32'h38;

  // Byte-to-word extension used by switch reads (lb vs lbu).
  function automatic logic [DATA_W-1:0] ext_byte(input logic [BANK_W-1:0] b,
                                                 input logic              is_signed);
    return {{(DATA_W-BANK_W){b[BANK_W-1] & is_signed}}, b};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-count debouncer and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  // Pulses in the cycle whose posedge raises the level, so events land with it.
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/mmio_io_bridge.sv
// IO register window beside data memory: LEDs, switches, buttons, 7-seg, cycle counter.
module mmio_io_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'hFFFF0000,
  parameter int unsigned NUM_LED    = 2,
  parameter int unsigned NUM_SW     = 2,
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      io_read,
  input  logic                      io_write,
  input  logic                      is_signed,
  input  logic [31:0]               addr,
  input  logic [31:0]               din,
  output logic [31:0]               dout,
  output logic                      io_hit,
  input  logic [BANK_W*NUM_SW-1:0]  sw,
  input  logic [NUM_BTN-1:0]        btn,
  output logic [BANK_W*NUM_LED-1:0] led,
  output logic [31:0]               seg_val,
  output logic                      irq
);

  logic [BANK_W*NUM_SW-1:0]  sw_s1_q, sw_s2_q;
  logic [BANK_W*NUM_LED-1:0] led_q, led_d;
  logic [DATA_W-1:0]         seg_q, seg_d;
  logic [NUM_BTN-1:0]        evt_q, evt_d, evt_clr;
  logic                      irq_q;
  logic [DATA_W-1:0]         cyc_q;
  logic [NUM_BTN-1:0]        btn_lvl, btn_rise;

  logic                      win;
  logic [7:0]                off;
  logic [NUM_LED-1:0]        led_sel;
  logic [NUM_SW-1:0]         sw_sel;
  logic                      seg_hit, lvl_hit, evt_hit, cyc_hit;
  logic [DATA_W-1:0]         rdata;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (btn_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  // Address decode: upper 24 bits select the window, low byte the register.
  always_comb begin
    win     = (addr[31:8] == BASE[31:8]);
    off     = addr[7:0];
    led_sel = '0;
    sw_sel  = '0;
    for (int k = 0; k < NUM_LED; k++) begin
      led_sel[k] = win && (off == 8'(OFF_LED0 + REG_STRIDE * k));
    end
    for (int k = 0; k < NUM_SW; k++) begin
      sw_sel[k] = win && (off == 8'(OFF_SW0 + REG_STRIDE * k));
    end
    seg_hit = win && (off == 8'(OFF_SEG));
    lvl_hit = win && (off == 8'(OFF_BTN_LVL));
    evt_hit = win && (off == 8'(OFF_BTN_EVT));
    cyc_hit = win && (off == 8'(OFF_CYC));
  end

  assign io_hit = (|led_sel) | (|sw_sel) | seg_hit | lvl_hit | evt_hit | cyc_hit;

  // Zero-latency read mux from registered state only.
  always_comb begin
    rdata = '0;
    if (io_read) begin
      for (int k = 0; k < NUM_LED; k++) begin
        if (led_sel[k]) rdata = DATA_W'(led_q[BANK_W*k +: BANK_W]);
      end
      for (int k = 0; k < NUM_SW; k++) begin
        if (sw_sel[k]) rdata = ext_byte(sw_s2_q[BANK_W*k +: BANK_W], is_signed);
      end
      if (seg_hit) rdata = seg_q;
      if (lvl_hit) rdata = DATA_W'(btn_lvl);
      if (evt_hit) rdata = DATA_W'(evt_q);
      if (cyc_hit) rdata = cyc_q;
    end
  end

  assign dout = rdata;

  // Write path and event bookkeeping; a new rise beats a same-cycle clear.
  always_comb begin
    led_d   = led_q;
    seg_d   = seg_q;
    evt_clr = '0;
    for (int k = 0; k < NUM_LED; k++) begin
      if (io_write && led_sel[k]) led_d[BANK_W*k +: BANK_W] = din[BANK_W-1:0];
    end
    if (io_write && seg_hit) seg_d = din;
    if (evt_hit) begin
      if (io_read)  evt_clr = '1;
      if (io_write) evt_clr = evt_clr | din[NUM_BTN-1:0];
    end
    evt_d = (evt_q & ~evt_clr) | btn_rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      led_q   <= '0;
      seg_q   <= '0;
      evt_q   <= '0;
      irq_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      led_q   <= led_d;
      seg_q   <= seg_d;
      evt_q   <= evt_d;
      irq_q   <= |evt_d;
      cyc_q   <= cyc_q + DATA_W'(1);
    end
  end

  assign led     = led_q;
  assign seg_val = seg_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed scoreboard bench for mmio_io_bridge with a short debounce window.
module tb_mmio_io_bridge;

  localparam int unsigned NUM_LED = 2;
  localparam int unsigned NUM_SW  = 2;
  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned DEB     = 8;

  localparam logic [31:0] A_LED0 = 32'hFFFF0000;
  localparam logic [31:0] A_LED1 = 32'hFFFF0004;
  localparam logic [31:0] A_SW0  = 32'hFFFF0010;
  localparam logic [31:0] A_SW1  = 32'hFFFF0014;
  localparam logic [31:0] A_SEG  = 32'hFFFF0020;
  localparam logic [31:0] A_LVL  = 32'hFFFF0030;
  localparam logic [31:0] A_EVT  = 32'hFFFF0034;
  localparam logic [31:0] A_CYC  = 32'hFFFF0038;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   io_read = 1'b0;
  logic                   io_write = 1'b0;
  logic                   is_signed = 1'b0;
  logic [31:0]            addr = 32'h0;
  logic [31:0]            din = 32'h0;
  logic [31:0]            dout;
  logic                   io_hit;
  logic [8*NUM_SW-1:0]    sw = '0;
  logic [NUM_BTN-1:0]     btn = '0;
  logic [8*NUM_LED-1:0]   led;
  logic [31:0]            seg_val;
  logic                   irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  mmio_io_bridge #(
    .BASE(32'hFFFF0000), .NUM_LED(NUM_LED), .NUM_SW(NUM_SW),
    .NUM_BTN(NUM_BTN), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .io_read(io_read), .io_write(io_write),
    .is_signed(is_signed), .addr(addr), .din(din), .dout(dout),
    .io_hit(io_hit), .sw(sw), .btn(btn), .led(led), .seg_val(seg_val),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic s, input logic [31:0] exp_d,
                    input logic exp_hit, input string tag);
    addr = a; is_signed = s; io_read = 1'b1;
    expect_val(exp_d);
    expect_val(32'(exp_hit));
    #1;
    check({tag, "_dout"}, dout);
    check({tag, "_hit"}, 32'(io_hit));
    io_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; io_write = 1'b1;
    tick();
    io_write = 1'b0;
  endtask

  initial begin
    // Reset state with no access.
    addr = A_CYC;
    repeat (3) tick();
    expect_val(32'h0); check("rst_led", 32'(led));
    expect_val(32'h0); check("rst_seg", seg_val);
    expect_val(32'h0); check("rst_irq", 32'(irq));
    expect_val(32'h0); check("rst_dout", dout);
    rst = 1'b1;
    rd(A_CYC, 1'b0, 32'd0, 1'b1, "cyc0");
    tick();
    rd(A_CYC, 1'b0, 32'd1, 1'b1, "cyc1");
    tick();
    rd(A_CYC, 1'b0, 32'd2, 1'b1, "cyc2");

    // LED / SEG writes and read-back.
    wr(A_LED1, 32'h000000A5);
    wr(A_SEG, 32'h12345678);
    expect_val(32'h0000A500); check("led_after_wr", 32'(led));
    expect_val(32'h12345678); check("seg_after_wr", seg_val);
    rd(A_LED1, 1'b0, 32'h000000A5, 1'b1, "rd_led1");
    rd(A_LED0, 1'b0, 32'h00000000, 1'b1, "rd_led0");
    rd(A_SEG, 1'b0, 32'h12345678, 1'b1, "rd_seg");

    // Switch synchroniser latency and sign extension.
    sw = 16'h0080;
    tick();
    rd(A_SW0, 1'b1, 32'h00000000, 1'b1, "sw0_1cyc");
    tick();
    rd(A_SW0, 1'b1, 32'hFFFFFF80, 1'b1, "sw0_signed");
    rd(A_SW0, 1'b0, 32'h00000080, 1'b1, "sw0_unsigned");
    sw = 16'h7F80;
    repeat (2) tick();
    rd(A_SW1, 1'b1, 32'h0000007F, 1'b1, "sw1_pos_signed");

    // Short pulses on btn[2] must not change level or raise events.
    btn = 4'b0100; tick(); btn = 4'b0000;
    repeat (12) tick();
    btn = 4'b0100; repeat (5) tick(); btn = 4'b0000;
    repeat (12) tick();
    rd(A_LVL, 1'b0, 32'h0, 1'b1, "glitch_lvl");
    rd(A_EVT, 1'b0, 32'h0, 1'b1, "glitch_evt");
    expect_val(32'h0); check("glitch_irq", 32'(irq));

    // Held press: level and event appear DEB+2 posedges after the press.
    btn = 4'b0100;
    repeat (DEB + 1) tick();
    rd(A_LVL, 1'b0, 32'h0, 1'b1, "hold_lvl_early");
    tick();
    rd(A_LVL, 1'b0, 32'h4, 1'b1, "hold_lvl");
    rd(A_EVT, 1'b0, 32'h4, 1'b1, "hold_evt");
    expect_val(32'h1); check("hold_irq", 32'(irq));
    repeat (10) tick();
    btn = 4'b0000;
    repeat (12) tick();
    rd(A_LVL, 1'b0, 32'h0, 1'b1, "release_lvl");
    rd(A_EVT, 1'b0, 32'h4, 1'b1, "release_evt_kept");

    // Read-to-clear.
    addr = A_EVT; io_read = 1'b1;
    expect_val(32'h4); #1; check("r2c_dout", dout);
    tick(); io_read = 1'b0;
    rd(A_EVT, 1'b0, 32'h0, 1'b1, "r2c_evt");
    expect_val(32'h0); check("r2c_irq", 32'(irq));

    // Rising edge coinciding with the clearing read: set wins.
    btn = 4'b0100;
    repeat (DEB + 1) tick();
    addr = A_EVT; io_read = 1'b1;
    expect_val(32'h0); #1; check("coinc_dout_pre", dout);
    tick(); io_read = 1'b0;
    rd(A_EVT, 1'b0, 32'h4, 1'b1, "coinc_evt");
    expect_val(32'h1); check("coinc_irq", 32'(irq));

    // W1C write clears only the written bits.
    wr(A_EVT, 32'h00000002);
    rd(A_EVT, 1'b0, 32'h4, 1'b1, "w1c_other");
    wr(A_EVT, 32'h00000004);
    rd(A_EVT, 1'b0, 32'h0, 1'b1, "w1c_evt");
    expect_val(32'h0); check("w1c_irq", 32'(irq));

    // Unmapped addresses: no hit, zero data, writes ignored.
    rd(32'hFFFF003C, 1'b0, 32'h0, 1'b0, "unm_3c");
    rd(32'hFFFF0100, 1'b0, 32'h0, 1'b0, "unm_100");
    rd(32'hFFFF0008, 1'b0, 32'h0, 1'b0, "unm_led2");
    wr(32'hFFFF0008, 32'hFFFFFFFF);
    wr(32'hFFFF003C, 32'hFFFFFFFF);
    wr(32'hFFFF0100, 32'hFFFFFFFF);
    wr(A_SW0, 32'hFFFFFFFF);
    wr(A_LVL, 32'hFFFFFFFF);
    expect_val(32'h0000A500); check("unm_led_kept", 32'(led));
    expect_val(32'h12345678); check("unm_seg_kept", seg_val);

    // Simultaneous read and write: old value visible, write lands.
    addr = A_SEG; din = 32'hDEADBEEF; io_read = 1'b1; io_write = 1'b1;
    expect_val(32'h12345678); #1; check("rw_dout_pre", dout);
    tick(); io_read = 1'b0; io_write = 1'b0;
    expect_val(32'hDEADBEEF); check("rw_seg_post", seg_val);

    // Reset mid-debounce discards the count; a held button fires DEB+2 after release.
    btn = 4'b0101;
    repeat (6) tick();
    rst = 1'b0;
    tick();
    expect_val(32'h0); check("rst2_led", 32'(led));
    expect_val(32'h0); check("rst2_seg", seg_val);
    rst = 1'b1;
    rd(A_CYC, 1'b0, 32'd0, 1'b1, "rst2_cyc");
    repeat (DEB + 1) tick();
    rd(A_LVL, 1'b0, 32'h0, 1'b1, "rst2_lvl_early");
    tick();
    rd(A_LVL, 1'b0, 32'h5, 1'b1, "rst2_lvl");
    rd(A_EVT, 1'b0, 32'h5, 1'b1, "rst2_evt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
Parametrised memory-mapped IO bridge for the single-cycle CPU; successor to the fixed LED/switch/button/7-seg decoder.
- Decodes IO accesses in a 256-byte window at BASE.
- Synchronises switches; debounces buttons and latches press events (read-to-clear, irq).
- Holds LED banks and the 7-seg value; exposes a free-running cycle counter.
- Sits beside data memory; the CPU muxes `dout` when `io_hit` is asserted.

Parameters:
- BASE, 32'hFFFF0000, window base; bits [7:0] must be 0.
- NUM_LED, 2, number of 8-bit LED banks (1..4).
- NUM_SW, 2, number of 8-bit switch banks (1..4).
- NUM_BTN, 4, number of buttons (1..8).
- DEB_CYCLES, 100000, stable cycles required before a debounced level changes (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- io_read  in  1  IO load strobe from controller
- io_write  in  1  IO store strobe from controller
- is_signed  in  1  sign-extend switch reads (lb vs lbu)
- addr  in  32  byte address (ALU result)
- din  in  32  store data from register file
- dout  out  32  load data to register file
- io_hit  out  1  addr maps to a defined register
- sw  in  8*NUM_SW  raw switches, bank k = bits [8k+7:8k]
- btn  in  NUM_BTN  raw buttons, active-high
- led  out  8*NUM_LED  LED banks
- seg_val  out  32  value for the 7-seg driver
- irq  out  1  OR of pending press events

Behaviour:
- Offset map (off = addr[7:0], requires addr[31:8]==BASE[31:8]):
  - LED k: 0x00+4k, k<NUM_LED, R/W.
  - SW k: 0x10+4k, k<NUM_SW, RO.
  - SEG: 0x20, R/W.
  - BTN_LVL: 0x30, RO.
  - BTN_EVT: 0x34, R/W1C.
  - CYC: 0x38, RO.
  - Any other offset is unmapped; `io_hit` is 0.
- Reads are combinational from registered state, zero latency. `dout` is 0 when io_read is low or the address is unmapped.
- LED and SEG reads return {24'h0, led_k} and seg_val respectively.
- SW read: {24{sw_k[7]&is_signed}, sw_k}, taken from a 2-flop synchroniser output.
- BTN_LVL read: zero-extended debounced levels.
- Writes take effect on the posedge when io_write and the address is mapped:
  - LED k <= din[7:0].
  - SEG <= din.
  - BTN_EVT clears bits where din=1.
  - Writes to RO or unmapped offsets are ignored.
- io_read and io_write asserted together: the write happens; dout shows the pre-write value.
- Button path, per button: 2-flop synchroniser, then debounce.
  - Counter resets to 0 whenever the synced input equals the debounced level.
  - Otherwise the counter increments.
  - When the count reaches DEB_CYCLES-1, the level toggles and the counter clears.
  - A pulse shorter than DEB_CYCLES cycles never changes the level.
- Event bit i is set on a 0->1 debounced transition. It is cleared at the posedge of a BTN_EVT read, or by a W1C write.
- A new rising edge in the same cycle as a clear leaves the bit set (set wins).
- irq = |evt, registered state only.
- CYC increments every cycle and wraps 32'hFFFFFFFF -> 0.
- Reset (async, rst=0): led, seg_val, evt, debounced levels, debounce counters, synchronisers and CYC all go to 0. Consequences:
  - irq=0 and dout=0 while io_read is low.
  - A button held through reset release registers one event after DEB_CYCLES+2 cycles.
- Reset asserted mid-debounce discards the partial count.

Decomposition:
- Package `mmio_pkg`: offset localparams OFF_LED0, OFF_SW0, OFF_SEG, OFF_BTN_LVL, OFF_BTN_EVT, OFF_CYC, and the stride value 4.
- Sub-module `btn_debounce` (params DEB_CYCLES; ports clk, rst, raw, level, rise) holds synchroniser, counter and edge detect. Instantiated NUM_BTN times via generate.
- Width of the debounce counter is $clog2(DEB_CYCLES).

Test Plan (DEB_CYCLES=8 for sim):
- Reset, no access -> led=0, seg_val=0, irq=0, dout=0; CYC reads 0 right after release, then increments by 1 per cycle.
- Write 0xA5 to 0xFFFF0004, then 0x12345678 to 0xFFFF0020 -> led[15:8]=0xA5, seg_val=0x12345678. Read-back returns 0x000000A5 and 0x12345678.
- sw bank0=0x80; read 0xFFFF0010 with is_signed=1 -> 0xFFFFFF80; with is_signed=0 -> 0x00000080. Value is valid 2 cycles after sw changes.
- btn[2] 1-cycle glitches and a 5-cycle pulse -> BTN_LVL and evt stay 0. Hold btn[2] for 20 cycles -> BTN_LVL=0x4 and evt=0x4 at cycle 10 after the press, irq=1.
- Read 0xFFFF0034 -> returns 0x4; next cycle evt=0, irq=0. Repeat with a rising edge coinciding with the clear -> bit remains 1.
- Read 0xFFFF003C, 0xFFFF0100, and LED offset 0x08 with NUM_LED=2 -> io_hit=0, dout=0. Writes to these addresses leave all state unchanged.
